// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_controller
// Description : VGA raster timing generator with one-tick pixel pipeline.
//               Exposes the upcoming scan position and registers colour/sync.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixelEn,
    input  logic [7:0]  pixelIn,
    output logic [15:0] nextX,
    output logic [15:0] nextY,
    output logic [2:0]  vgaRed,
    output logic [2:0]  vgaGreen,
    output logic [1:0]  vgaBlue,
    output logic        hsync,
    output logic        vsync,
    output logic        activeVideo,
    output logic        frameTick
);

    localparam logic [15:0] c_H_ACTIVE   = 16'(H_ACTIVE);
    localparam logic [15:0] c_H_LAST     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] c_H_SYNC_LO  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_H_SYNC_HI  = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] c_V_ACTIVE   = 16'(V_ACTIVE);
    localparam logic [15:0] c_V_LAST     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] c_V_SYNC_LO  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_V_SYNC_HI  = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] r_h_count;
    logic [15:0] r_v_count;
    logic [2:0]  r_red;
    logic [2:0]  r_green;
    logic [1:0]  r_blue;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_frame_tick;

    logic        w_h_wrap;
    logic [15:0] w_next_x;
    logic [15:0] w_next_y;
    logic        w_next_visible;

    // The counters hold the displayed position; the next position is what the
    // pixel generator must be rendering now so its colour lands one tick later.
    always_comb begin
        w_h_wrap = (r_h_count == c_H_LAST);
        w_next_x = w_h_wrap ? 16'd0 : r_h_count + 16'd1;
        w_next_y = r_v_count;
        if (w_h_wrap) begin
            w_next_y = (r_v_count == c_V_LAST) ? 16'd0 : r_v_count + 16'd1;
        end
        w_next_visible = (w_next_x < c_H_ACTIVE) && (w_next_y < c_V_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Parked on the last position so the first tick shows (0,0).
            r_h_count    <= c_H_LAST;
            r_v_count    <= c_V_LAST;
            r_red        <= 3'd0;
            r_green      <= 3'd0;
            r_blue       <= 2'd0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_active     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (pixelEn) begin
            r_h_count    <= w_next_x;
            r_v_count    <= w_next_y;
            r_red        <= w_next_visible ? pixelIn[7:5] : 3'd0;
            r_green      <= w_next_visible ? pixelIn[4:2] : 3'd0;
            r_blue       <= w_next_visible ? pixelIn[1:0] : 2'd0;
            r_active     <= w_next_visible;
            r_hsync      <= !((w_next_x >= c_H_SYNC_LO) && (w_next_x < c_H_SYNC_HI));
            r_vsync      <= !((w_next_y >= c_V_SYNC_LO) && (w_next_y < c_V_SYNC_HI));
            r_frame_tick <= (w_next_x == 16'd0) && (w_next_y == c_V_ACTIVE);
        end else begin
            // Pulse must stay one clk wide even when ticks are sparse.
            r_frame_tick <= 1'b0;
        end
    end

    assign nextX       = w_next_x;
    assign nextY       = w_next_y;
    assign vgaRed      = r_red;
    assign vgaGreen    = r_green;
    assign vgaBlue     = r_blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign activeVideo = r_active;
    assign frameTick   = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- pixelEn  in  1  pixel-rate tick; all counters and registered outputs advance only on clk edges with pixelEn=1.
- pixelIn  in  8  RGB332 colour returned by pixel generation logic for nextX/nextY.
- nextX  out  16  column to be displayed at the next pixel tick; zero-extended.
- nextY  out  16  line to be displayed at the next pixel tick; zero-extended.
- vgaRed  out  3  pixelIn[7:5], registered.
- vgaGreen  out  3  pixelIn[4:2], registered.
- vgaBlue  out  2  pixelIn[1:0], registered.
- hsync  out  1  active-low horizontal sync, registered.
- vsync  out  1  active-low vertical sync, registered.
- activeVideo  out  1  high while the current position is visible.
- frameTick  out  1  one-clk pulse at start of vertical blanking.

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-004 Internal counters hCount (0..H_TOTAL-1) and vCount (0..V_TOTAL-1) SHALL hold the currently displayed position.
REQ-005 On a pixelEn tick, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-006 vCount SHALL increment on the same tick as hCount wraps; at V_TOTAL-1 it SHALL wrap to 0.
REQ-007 nextX/nextY SHALL be combinational from the counters: the position the counters take on the next pixelEn tick, including both wraps.
REQ-008 On each pixelEn tick, vgaRed/vgaGreen/vgaBlue SHALL capture pixelIn if the new position is visible (x<H_ACTIVE and y<V_ACTIVE), else 0. Latency from nextX/nextY to colour is exactly one pixel tick.
REQ-009 On each pixelEn tick, hsync SHALL register 0 if the new x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else 1.
REQ-010 On each pixelEn tick, vsync SHALL register 0 if the new y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else 1.
REQ-011 activeVideo SHALL be registered with the same timing as the colour outputs.
REQ-012 frameTick SHALL be 1 for exactly one clk cycle: the cycle after the pixelEn tick at which the counters become (0, V_ACTIVE). It SHALL be 0 at all other times, including cycles with pixelEn=0.
REQ-013 With pixelEn=0, all registered outputs and counters SHALL hold, and nextX/nextY SHALL be stable.
REQ-014 pixelIn SHALL be sampled only on pixelEn ticks; its value at other times SHALL have no effect.

Reset
REQ-015 rst_n=0 at a clk edge SHALL set hCount=H_TOTAL-1 and vCount=V_TOTAL-1, so nextX=0 and nextY=0. This applies regardless of pixelEn and mid-frame.
REQ-016 Reset values SHALL be: hsync=1, vsync=1, vgaRed/vgaGreen/vgaBlue=0, activeVideo=0, frameTick=0.
REQ-017 The first pixelEn tick after reset release SHALL display position (0,0).

Verification
REQ-018 Reset, then pixelEn=1 constantly with pixelIn=8'hFF -> first tick gives RGB=7/7/3 and activeVideo=1; nextX=1, nextY=0.
REQ-019 Run one full line -> hsync=0 for exactly 96 ticks starting at x=656; RGB=0 for x 640..799; nextX wraps 799->0 and nextY increments.
REQ-020 Run two frames -> vsync low for 2 lines (y=490,491); frameTick pulses exactly once per 420000 ticks, at (0,480).
REQ-021 pixelEn asserted every 4th clk -> outputs change only on tick edges; frameTick is 1 clk wide; line period is 3200 clk.
REQ-022 pixelIn driven as function of nextX (pixelIn=nextX[7:0]) -> displayed colour at x equals x[7:0] on every visible pixel (one-tick alignment).
REQ-023 rst_n=0 for one clk mid-frame at (300,200) -> all outputs take reset values; nextX=0, nextY=0; the next tick shows (0,0).
